ps2_cmd_decoder: RTL and testbench

//   Next-generation PS/2 keyboard command decoder for the music player.

---
 rtl/ps2_cmd_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_cmd_decoder.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code command decoder for the music player.
// Pops bytes from the keyboard FIFO, tracks F0/E0 prefixes, drives player
// controls and a small polyphonic note table with key-on/key-off events.
module ps2_cmd_decoder #(
   parameter int NUM_VOICES = 4,
   parameter int VOL_W      = 5,
   parameter int VOL_MAX    = 16,
   parameter int VOL_INIT   = 4,
   parameter int NUM_MODES  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              data,
   input  logic                    ready,
   output logic                    nextdata_n,
   output logic                    start,
   output logic [1:0]              mode,
   output logic                    next_pulse,
   output logic                    restart_pulse,
   output logic [VOL_W-1:0]        vol,
   output logic [NUM_VOICES-1:0]   voice_on,
   output logic [4*NUM_VOICES-1:0] voice_note,
   output logic                    note_evt,
   output logic                    note_evt_on,
   output logic [3:0]              note_evt_code
);

   localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

   state_t                  state, state_nx;
   logic [PTR_W-1:0]        steal_ptr, steal_ptr_nx;
   logic                    nextdata_n_nx, start_nx, next_nx, restart_nx;
   logic [1:0]              mode_nx;
   logic [VOL_W-1:0]        vol_nx;
   logic [NUM_VOICES-1:0]   voice_on_nx;
   logic [4*NUM_VOICES-1:0] voice_note_nx;
   logic                    evt_nx, evt_on_nx;
   logic [3:0]              evt_code_nx;

   logic                    consume, do_make, do_break, do_ext;
   logic [3:0]              note;
   logic                    hit, free;
   logic [PTR_W-1:0]        hit_idx, free_idx;

   // Scan code to note number; 0 means "not a note key".
   function automatic logic [3:0] note_of(input logic [7:0] code);
      case (code)
         8'h15: note_of = 4'd1;
         8'h1D: note_of = 4'd2;
         8'h24: note_of = 4'd3;
         8'h2D: note_of = 4'd4;
         8'h2C: note_of = 4'd5;
         8'h35: note_of = 4'd6;
         8'h3C: note_of = 4'd7;
         8'h1C: note_of = 4'd8;
         8'h1B: note_of = 4'd9;
         8'h23: note_of = 4'd10;
         8'h2B: note_of = 4'd11;
         8'h34: note_of = 4'd12;
         8'h33: note_of = 4'd13;
         8'h3B: note_of = 4'd14;
         default: note_of = 4'd0;
      endcase
   endfunction

   // Slot lookup: which slot already holds this note, and the lowest free slot.
   always_comb begin
      note     = note_of(data);
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_on[i] && voice_note[4*i +: 4] == note) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!voice_on[i]) begin
            free     = 1'b1;
            free_idx = PTR_W'(i);
         end
      end
   end

   // Parser next state and next values of every registered output.
   always_comb begin
      state_nx      = state;
      steal_ptr_nx  = steal_ptr;
      start_nx      = start;
      mode_nx       = mode;
      vol_nx        = vol;
      voice_on_nx   = voice_on;
      voice_note_nx = voice_note;
      next_nx       = 1'b0;
      restart_nx    = 1'b0;
      evt_nx        = 1'b0;
      evt_on_nx     = 1'b0;
      evt_code_nx   = 4'd0;
      do_make       = 1'b0;
      do_break      = 1'b0;
      do_ext        = 1'b0;

      // The pop cycle itself (nextdata_n low) never consumes, so each byte is taken once.
      consume       = ready && nextdata_n;
      nextdata_n_nx = !consume;

      if (consume) begin
         case (state)
            S_IDLE: begin
               if (data == 8'hF0)      state_nx = S_BRK;
               else if (data == 8'hE0) state_nx = S_EXT;
               else                    do_make  = 1'b1;
            end
            S_BRK: begin
               if (data != 8'hF0) begin
                  do_break = 1'b1;
                  state_nx = S_IDLE;
               end
            end
            S_EXT: begin
               if (data == 8'hF0) state_nx = S_EXT_BRK;
               else if (data != 8'hE0) begin
                  do_ext   = 1'b1;
                  state_nx = S_IDLE;
               end
            end
            default: state_nx = S_IDLE;  // extended break: byte discarded
         endcase
      end

      if (do_make) begin
         case (data)
            8'h5A: start_nx = !start;
            8'h16: if (0 < NUM_MODES) mode_nx = 2'd0;
            8'h1E: if (1 < NUM_MODES) mode_nx = 2'd1;
            8'h26: if (2 < NUM_MODES) mode_nx = 2'd2;
            default: begin
               // A held note repeating (typematic) is silent; otherwise allocate or steal.
               if (note != 4'd0 && !hit) begin
                  evt_nx      = 1'b1;
                  evt_on_nx   = 1'b1;
                  evt_code_nx = note;
                  if (free) begin
                     voice_on_nx[free_idx]                     = 1'b1;
                     voice_note_nx[4*int'(free_idx) +: 4]      = note;
                  end else begin
                     voice_on_nx[steal_ptr]                    = 1'b1;
                     voice_note_nx[4*int'(steal_ptr) +: 4]     = note;
                     steal_ptr_nx = (steal_ptr == PTR_W'(NUM_VOICES - 1)) ? '0
                                                                          : steal_ptr + 1'b1;
                  end
               end
            end
         endcase
      end

      if (do_break && note != 4'd0 && hit) begin
         voice_on_nx[hit_idx]                = 1'b0;
         voice_note_nx[4*int'(hit_idx) +: 4] = 4'd0;
         evt_nx      = 1'b1;
         evt_on_nx   = 1'b0;
         evt_code_nx = note;
      end

      if (do_ext) begin
         case (data)
            8'h75: if (vol != '0) vol_nx = vol - 1'b1;
            8'h72: if (vol < VOL_W'(VOL_MAX)) vol_nx = vol + 1'b1;
            8'h74: next_nx = 1'b1;
            8'h6B: restart_nx = 1'b1;
            default: ;
         endcase
      end
   end

   // State and output registers; reset overrides any byte in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         steal_ptr     <= '0;
         nextdata_n    <= 1'b1;
         start         <= 1'b0;
         mode          <= 2'd1;
         vol           <= VOL_W'(VOL_INIT);
         voice_on      <= '0;
         voice_note    <= '0;
         next_pulse    <= 1'b0;
         restart_pulse <= 1'b0;
         note_evt      <= 1'b0;
         note_evt_on   <= 1'b0;
         note_evt_code <= 4'd0;
      end else begin
         state         <= state_nx;
         steal_ptr     <= steal_ptr_nx;
         nextdata_n    <= nextdata_n_nx;
         start         <= start_nx;
         mode          <= mode_nx;
         vol           <= vol_nx;
         voice_on      <= voice_on_nx;
         voice_note    <= voice_note_nx;
         next_pulse    <= next_nx;
         restart_pulse <= restart_nx;
         note_evt      <= evt_nx;
         note_evt_on   <= evt_on_nx;
         note_evt_code <= evt_code_nx;
      end
   end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Bench for ps2_cmd_decoder: directed scenarios plus randomized byte streams,
// all compared against a byte-level behavioural model of the decoder.
module tb_ps2_cmd_decoder;

   localparam int NV    = 4;
   localparam int VW    = 5;
   localparam int VMAX  = 16;
   localparam int VINIT = 4;
   localparam int NM    = 2;

   logic clk = 1'b0;
   logic rst, ready;
   logic [7:0] data;
   logic nextdata_n, start, next_pulse, restart_pulse, note_evt, note_evt_on;
   logic [1:0] mode;
   logic [VW-1:0] vol;
   logic [NV-1:0] voice_on;
   logic [4*NV-1:0] voice_note;
   logic [3:0] note_evt_code;

   ps2_cmd_decoder #(.NUM_VOICES(NV), .VOL_W(VW), .VOL_MAX(VMAX), .VOL_INIT(VINIT),
                     .NUM_MODES(NM)) dut (
      .clk(clk), .rst(rst), .data(data), .ready(ready), .nextdata_n(nextdata_n),
      .start(start), .mode(mode), .next_pulse(next_pulse), .restart_pulse(restart_pulse),
      .vol(vol), .voice_on(voice_on), .voice_note(voice_note), .note_evt(note_evt),
      .note_evt_on(note_evt_on), .note_evt_code(note_evt_code));

   always #10 clk = ~clk;

   typedef struct packed {
      logic          nd_n;
      logic          start;
      logic [1:0]    mode;
      logic [VW-1:0] vol;
      logic [NV-1:0] von;
      logic [4*NV-1:0] vnote;
      logic          nxt;
      logic          rsp;
      logic          evt;
      logic          evt_on;
      logic [3:0]    evt_code;
   } snap_t;

   int vectors = 0, miscompares = 0;
   int pops = 0, ons = 0, offs = 0;
   snap_t obs1, obs2, exp1, exp2;

   // Reference model state
   bit m_start, m_brk, m_ext;
   int m_mode, m_vol, m_ptr;
   bit m_on[NV];
   int m_note[NV];
   bit e_nxt, e_rsp, e_evt, e_on;
   int e_code;

   // Count FIFO pops as seen on the bus
   always @(posedge clk) if (!rst && !nextdata_n) pops++;

   function automatic int note_of(input logic [7:0] b);
      case (b)
         8'h15: return 1;  8'h1D: return 2;  8'h24: return 3;  8'h2D: return 4;
         8'h2C: return 5;  8'h35: return 6;  8'h3C: return 7;  8'h1C: return 8;
         8'h1B: return 9;  8'h23: return 10; 8'h2B: return 11; 8'h34: return 12;
         8'h33: return 13; 8'h3B: return 14;
         default: return 0;
      endcase
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s = '{nd_n: nextdata_n, start: start, mode: mode, vol: vol, von: voice_on,
            vnote: voice_note, nxt: next_pulse, rsp: restart_pulse, evt: note_evt,
            evt_on: note_evt ? note_evt_on : 1'b0,
            evt_code: note_evt ? note_evt_code : 4'd0};
      return s;
   endfunction

   function automatic snap_t expect_now(input logic nd_n);
      snap_t s;
      s = '0;
      s.nd_n = nd_n; s.start = m_start; s.mode = 2'(m_mode); s.vol = VW'(m_vol);
      for (int i = 0; i < NV; i++) begin
         s.von[i] = m_on[i];
         s.vnote[4*i +: 4] = 4'(m_note[i]);
      end
      s.nxt = e_nxt; s.rsp = e_rsp; s.evt = e_evt; s.evt_on = e_on; s.evt_code = 4'(e_code);
      return s;
   endfunction

   task automatic model_reset();
      m_start = 0; m_mode = 1; m_vol = VINIT; m_ptr = 0; m_brk = 0; m_ext = 0;
      for (int i = 0; i < NV; i++) begin m_on[i] = 0; m_note[i] = 0; end
      e_nxt = 0; e_rsp = 0; e_evt = 0; e_on = 0; e_code = 0;
   endtask

   task automatic model_make(input logic [7:0] b);
      int n, slot;
      bit held;
      n = note_of(b);
      case (b)
         8'h5A: m_start = !m_start;
         8'h16: if (0 < NM) m_mode = 0;
         8'h1E: if (1 < NM) m_mode = 1;
         8'h26: if (2 < NM) m_mode = 2;
         default: if (n != 0) begin
            held = 0;
            foreach (m_on[i]) if (m_on[i] && m_note[i] == n) held = 1;
            if (!held) begin
               slot = -1;
               for (int i = NV - 1; i >= 0; i--) if (!m_on[i]) slot = i;
               if (slot < 0) begin
                  slot = m_ptr;
                  m_ptr = (m_ptr + 1) % NV;
               end
               m_on[slot] = 1; m_note[slot] = n;
               e_evt = 1; e_on = 1; e_code = n;
            end
         end
      endcase
   endtask

   task automatic model_break(input logic [7:0] b);
      int n;
      n = note_of(b);
      if (n != 0)
         foreach (m_on[i]) if (m_on[i] && m_note[i] == n) begin
            m_on[i] = 0; m_note[i] = 0;
            e_evt = 1; e_on = 0; e_code = n;
         end
   endtask

   task automatic model_ext(input logic [7:0] b);
      case (b)
         8'h75: if (m_vol > 0) m_vol--;
         8'h72: if (m_vol < VMAX) m_vol++;
         8'h74: e_nxt = 1;
         8'h6B: e_rsp = 1;
         default: ;
      endcase
   endtask

   task automatic model_byte(input logic [7:0] b);
      e_nxt = 0; e_rsp = 0; e_evt = 0; e_on = 0; e_code = 0;
      if (m_brk && m_ext) begin m_brk = 0; m_ext = 0; end
      else if (m_brk) begin
         if (b != 8'hF0) begin model_break(b); m_brk = 0; end
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b != 8'hE0) begin model_ext(b); m_ext = 0; end
      end else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else model_make(b);
   endtask

   // Present one byte, capture outputs after the consume edge (obs1) and
   // after the pop cycle (obs2), during which ready stays high with junk data.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data = b; ready = 1'b1;
      model_byte(b);
      @(posedge clk); #1;
      obs1 = observe(); exp1 = expect_now(1'b0);
      if (obs1.evt) begin if (obs1.evt_on) ons++; else offs++; end
      e_nxt = 0; e_rsp = 0; e_evt = 0; e_on = 0; e_code = 0;
      data = 8'($urandom);
      @(posedge clk); #1;
      obs2 = observe(); exp2 = expect_now(1'b1);
      ready = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst = 1'b1; ready = 1'b1; data = 8'h5A;
      repeat (n) @(posedge clk);
      #1;
      obs1 = observe();
      @(negedge clk);
      rst = 1'b0; ready = 1'b0;
      model_reset();
      ons = 0; offs = 0;
   endtask

   task automatic test_reset();
      apply_reset(2);
      exp1 = expect_now(1'b1);
      vectors++;
      if (obs1 !== exp1) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected %h", obs1, exp1);
      end
      vectors++;
      if ({start, mode, vol, voice_on, nextdata_n} !== {1'b0, 2'd1, 5'd4, 4'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_fields: got %b expected %b",
                  {start, mode, vol, voice_on, nextdata_n}, {1'b0, 2'd1, 5'd4, 4'b0, 1'b1});
      end
   endtask

   task automatic test_idle();
      int p0;
      p0 = pops;
      repeat (8) begin
         @(posedge clk); #1;
         vectors++;
         if (nextdata_n !== 1'b1 || note_evt !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_pop: got nd_n=%b evt=%b expected nd_n=1 evt=0",
                     nextdata_n, note_evt);
         end
      end
      vectors++;
      if (pops != p0) begin
         miscompares++;
         $display("FAIL idle_pops: got %0d expected %0d", pops - p0, 0);
      end
   endtask

   task automatic test_start();
      logic [7:0] seq [3];
      logic exp_start [3];
      int p0;
      seq = '{8'h5A, 8'hF0, 8'h5A};
      exp_start = '{1'b1, 1'b1, 1'b1};
      p0 = pops;
      for (int k = 0; k < 3; k++) begin
         send_byte(seq[k]);
         vectors++;
         if (obs1 !== exp1 || obs1.start !== exp_start[k]) begin
            miscompares++;
            $display("FAIL start_seq[%0d]: got %h expected %h", k, obs1, exp1);
         end
         vectors++;
         if (obs2 !== exp2) begin
            miscompares++;
            $display("FAIL start_popend[%0d]: got %h expected %h", k, obs2, exp2);
         end
      end
      vectors++;
      if (pops - p0 != 3) begin
         miscompares++;
         $display("FAIL start_pops: got %0d expected 3", pops - p0);
      end
   endtask

   task automatic test_volume();
      logic [7:0] seq [$];
      apply_reset(1);
      for (int k = 0; k < 17; k++) begin
         seq = '{8'hE0, 8'h72};
         foreach (seq[j]) begin
            send_byte(seq[j]);
            vectors++;
            if (obs1 !== exp1 || obs2 !== exp2) begin
               miscompares++;
               $display("FAIL vol_up[%0d]: got %h/%h expected %h/%h", k, obs1, obs2, exp1, exp2);
            end
         end
      end
      vectors++;
      if (vol !== 5'd16) begin
         miscompares++;
         $display("FAIL vol_sat_max: got %0d expected 16", vol);
      end
      seq = '{8'hE0, 8'hF0, 8'h72, 8'hE0, 8'h75, 8'hE0, 8'h74, 8'hE0, 8'h6B};
      foreach (seq[j]) begin
         send_byte(seq[j]);
         vectors++;
         if (obs1 !== exp1 || obs2 !== exp2) begin
            miscompares++;
            $display("FAIL vol_misc[%0d]: got %h/%h expected %h/%h", j, obs1, obs2, exp1, exp2);
         end
         if (j == 4) begin
            vectors++;
            if (vol !== 5'd15) begin
               miscompares++;
               $display("FAIL vol_down: got %0d expected 15", vol);
            end
         end
         if (j == 6 || j == 8) begin
            vectors++;
            if ({obs1.nxt, obs1.rsp, obs2.nxt, obs2.rsp} !== ((j == 6) ? 4'b1000 : 4'b0100)) begin
               miscompares++;
               $display("FAIL ext_pulse[%0d]: got %b expected %b", j,
                        {obs1.nxt, obs1.rsp, obs2.nxt, obs2.rsp}, (j == 6) ? 4'b1000 : 4'b0100);
            end
         end
      end
      for (int k = 0; k < 17; k++) begin send_byte(8'hE0); send_byte(8'h75); end
      vectors++;
      if (vol !== 5'd0) begin
         miscompares++;
         $display("FAIL vol_sat_min: got %0d expected 0", vol);
      end
   endtask

   task automatic test_notes();
      logic [7:0] seq [5];
      seq = '{8'h15, 8'h1C, 8'h15, 8'hF0, 8'h15};
      apply_reset(1);
      foreach (seq[j]) begin
         send_byte(seq[j]);
         vectors++;
         if (obs1 !== exp1 || obs2 !== exp2) begin
            miscompares++;
            $display("FAIL notes[%0d]: got %h/%h expected %h/%h", j, obs1, obs2, exp1, exp2);
         end
         if (j == 2) begin
            vectors++;
            if ({voice_on, voice_note[7:0]} !== {4'b0011, 8'h81} || ons != 2) begin
               miscompares++;
               $display("FAIL notes_hold: got on=%b notes=%h ons=%0d expected on=0011 notes=81 ons=2",
                        voice_on, voice_note[7:0], ons);
            end
         end
      end
      vectors++;
      if (voice_on !== 4'b0010 || {obs1.evt, obs1.evt_on, obs1.evt_code} !== 6'b10_0001) begin
         miscompares++;
         $display("FAIL notes_keyoff: got on=%b evt=%b expected on=0010 evt=100001",
                  voice_on, {obs1.evt, obs1.evt_on, obs1.evt_code});
      end
   endtask

   task automatic test_steal();
      logic [7:0] seq [6];
      seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C};
      apply_reset(1);
      foreach (seq[j]) begin
         send_byte(seq[j]);
         vectors++;
         if (obs1 !== exp1 || obs2 !== exp2) begin
            miscompares++;
            $display("FAIL steal[%0d]: got %h/%h expected %h/%h", j, obs1, obs2, exp1, exp2);
         end
         if (j == 4) begin
            vectors++;
            if (voice_note !== 16'h4325 || voice_on !== 4'hF || ons != 5 || offs != 0) begin
               miscompares++;
               $display("FAIL steal_slot0: got notes=%h on=%b ons=%0d offs=%0d expected notes=4325 on=1111 ons=5 offs=0",
                        voice_note, voice_on, ons, offs);
            end
         end
      end
      vectors++;
      if (voice_note !== 16'h4385) begin
         miscompares++;
         $display("FAIL steal_ptr_next: got %h expected 4385", voice_note);
      end
   endtask

   task automatic test_mode();
      logic [7:0] seq [5];
      logic [1:0] exp_mode [5];
      seq = '{8'h16, 8'h26, 8'h1E, 8'hF0, 8'h16};
      exp_mode = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
      apply_reset(1);
      foreach (seq[j]) begin
         send_byte(seq[j]);
         vectors++;
         if (obs1 !== exp1 || mode !== exp_mode[j]) begin
            miscompares++;
            $display("FAIL mode[%0d]: got mode=%0d snap=%h expected mode=%0d snap=%h",
                     j, mode, obs1, exp_mode[j], exp1);
         end
      end
   endtask

   task automatic test_reset_prefix();
      apply_reset(1);
      send_byte(8'hF0);
      apply_reset(1);
      send_byte(8'h15);
      vectors++;
      if ({obs1.evt, obs1.evt_on, obs1.evt_code} !== 6'b11_0001 || obs1 !== exp1) begin
         miscompares++;
         $display("FAIL reset_clears_brk: got %h expected %h", obs1, exp1);
      end
      send_byte(8'hE0);
      apply_reset(1);
      send_byte(8'h5A);
      vectors++;
      if (start !== 1'b1 || obs1 !== exp1) begin
         miscompares++;
         $display("FAIL reset_clears_ext: got %h expected %h", obs1, exp1);
      end
   endtask

   task automatic test_random();
      logic [7:0] notes [14];
      logic [7:0] cmds [8];
      logic [7:0] b;
      notes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B};
      cmds  = '{8'h5A, 8'h16, 8'h1E, 8'h26, 8'h72, 8'h75, 8'h74, 8'h6B};
      apply_reset(1);
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 9))
            0: b = 8'hF0;
            1: b = 8'hE0;
            2: b = cmds[$urandom_range(0, 7)];
            3: b = 8'($urandom);
            default: b = notes[$urandom_range(0, 13)];
         endcase
         if ($urandom_range(0, 99) == 0) apply_reset(1);
         send_byte(b);
         vectors++;
         if (obs1 !== exp1 || obs2 !== exp2) begin
            miscompares++;
            $display("FAIL random[%0d] byte=%h: got %h/%h expected %h/%h",
                     k, b, obs1, obs2, exp1, exp2);
         end
      end
   endtask

   initial begin
      rst = 1'b1; ready = 1'b0; data = 8'h00;
      model_reset();
      test_reset();
      test_idle();
      test_start();
      test_volume();
      test_notes();
      test_steal();
      test_mode();
      test_reset_prefix();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
